// File: rtl/mips_alu_pkg.sv
// mips_alu_pkg: operation codes and FSM states shared by the multi-cycle MIPS ALU.
package mips_alu_pkg;
    localparam logic [3:0] ALU_AND   = 4'd0;
    localparam logic [3:0] ALU_OR    = 4'd1;
    localparam logic [3:0] ALU_ADD   = 4'd2;
    localparam logic [3:0] ALU_SUB   = 4'd6;
    localparam logic [3:0] ALU_SLT   = 4'd7;
    localparam logic [3:0] ALU_MULTU = 4'd8;
    localparam logic [3:0] ALU_DIVU  = 4'd9;
    localparam logic [3:0] ALU_NOR   = 4'd12;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
endpackage

// File: rtl/mips_muldiv_seq.sv
// mips_muldiv_seq: iterative shift-add multiplier / restoring divider, one bit per step.
module mips_muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             is_div,
    input  logic             step,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             last
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] acc, sh, dvs;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   sum, rem;
    logic             ge;

    // hi/lo are the post-step values, so the top can capture the final result on the last edge
    always_comb begin
        sum  = {1'b0, acc} + (sh[0] ? {1'b0, dvs} : '0);
        rem  = {acc, sh[WIDTH-1]};
        ge   = rem >= {1'b0, dvs};
        hi   = is_div ? (ge ? rem[WIDTH-1:0] - dvs : rem[WIDTH-1:0]) : sum[WIDTH:1];
        lo   = is_div ? {sh[WIDTH-2:0], ge} : {sum[0], sh[WIDTH-1:1]};
        last = cnt == CNT_W'(WIDTH - 1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc <= '0;
            sh  <= '0;
            dvs <= '0;
            cnt <= '0;
        end else if (load) begin
            acc <= '0;
            sh  <= A;
            dvs <= B;
            cnt <= '0;
        end else if (step) begin
            acc <= hi;
            sh  <= lo;
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/mips_alu_mc.sv
// mips_alu_mc: multi-cycle MIPS ALU with registered outputs and start/busy/done handshake.
module mips_alu_mc
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       ALUctl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_hi,
    output logic             Zero,
    output logic             Overflow,
    output logic             div_by_zero,
    output logic             busy,
    output logic             done
);
    state_t           state;
    logic [WIDTH-1:0] sum, dif, res, hi, lo;
    logic             ovf, last, iter, load;

    always_comb begin
        sum  = A + B;
        dif  = A - B;
        res  = (ALUctl == ALU_AND) ? A & B :
               (ALUctl == ALU_OR)  ? A | B :
               (ALUctl == ALU_ADD) ? sum :
               (ALUctl == ALU_SUB) ? dif :
               (ALUctl == ALU_SLT) ? {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)} :
               (ALUctl == ALU_NOR) ? ~(A | B) : '0;
        ovf  = (ALUctl == ALU_ADD) ? (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]) :
               (ALUctl == ALU_SUB) ? (A[WIDTH-1] != B[WIDTH-1]) && (dif[WIDTH-1] != A[WIDTH-1]) : 1'b0;
        iter = (ALUctl == ALU_MULTU) || (ALUctl == ALU_DIVU && B != '0);
        load = state == IDLE && start && iter;
    end

    mips_muldiv_seq #(.WIDTH(WIDTH)) u_seq (
        .clock(clock), .reset(reset), .load(load), .is_div(state == DIV),
        .step(state != IDLE), .A(A), .B(B), .hi(hi), .lo(lo), .last(last)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            out         <= '0;
            out_hi      <= '0;
            Zero        <= 1'b0;
            Overflow    <= 1'b0;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    if (iter) begin
                        state <= (ALUctl == ALU_DIVU) ? DIV : MUL;
                        busy  <= 1'b1;
                    end else if (ALUctl == ALU_DIVU) begin
                        out         <= '1;
                        out_hi      <= A;
                        Zero        <= 1'b0;
                        Overflow    <= 1'b0;
                        div_by_zero <= 1'b1;
                        done        <= 1'b1;
                    end else begin
                        out         <= res;
                        out_hi      <= '0;
                        Zero        <= res == '0;
                        Overflow    <= ovf;
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                    end
                end
                default: if (last) begin
                    state       <= IDLE;
                    out         <= lo;
                    out_hi      <= hi;
                    Zero        <= lo == '0;
                    Overflow    <= 1'b0;
                    div_by_zero <= 1'b0;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mips_alu_mc.sv
// tb_mips_alu_mc: vector table, hand sequences and random ops against an arithmetic reference model.
module tb_mips_alu_mc;
    logic        clock = 0, reset = 1;
    logic        start = 0, start8 = 0;
    logic [3:0]  ALUctl = 0, ctl8 = 0;
    logic [31:0] A = 0, B = 0, out, out_hi;
    logic [7:0]  a8 = 0, b8 = 0, out8, hi8;
    logic        Zero, Overflow, div_by_zero, busy, done;
    logic        z8, ov8, dbz8, busy8, done8;
    int          total = 0, bad = 0;

    typedef struct {
        logic [31:0] o, h;
        logic        z, ov, dbz;
        int          lat;
    } res_t;

    typedef struct {
        logic [3:0]  c;
        logic [31:0] a, b;
        res_t        e;
    } vec_t;

    mips_alu_mc #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(start), .ALUctl(ALUctl), .A(A), .B(B),
        .out(out), .out_hi(out_hi), .Zero(Zero), .Overflow(Overflow),
        .div_by_zero(div_by_zero), .busy(busy), .done(done)
    );

    mips_alu_mc #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .start(start8), .ALUctl(ctl8), .A(a8), .B(b8),
        .out(out8), .out_hi(hi8), .Zero(z8), .Overflow(ov8),
        .div_by_zero(dbz8), .busy(busy8), .done(done8)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic res_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        res_t        r;
        longint      sa, sb, t;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = '{o: 0, h: 0, z: 0, ov: 0, dbz: 0, lat: 1};
        case (c)
            4'd0:  r.o = a & b;
            4'd1:  r.o = a | b;
            4'd2:  begin t = sa + sb; r.o = t[31:0]; r.ov = t > 64'sd2147483647 || t < -64'sd2147483648; end
            4'd6:  begin t = sa - sb; r.o = t[31:0]; r.ov = t > 64'sd2147483647 || t < -64'sd2147483648; end
            4'd7:  r.o = (sa < sb) ? 32'd1 : 32'd0;
            4'd12: r.o = ~(a | b);
            4'd8:  begin p = 64'(a) * 64'(b); r.h = p[63:32]; r.o = p[31:0]; r.lat = 33; end
            4'd9:  if (b == 0) begin r.o = '1; r.h = a; r.dbz = 1; end
                   else begin r.o = a / b; r.h = a % b; r.lat = 33; end
            default: r.o = 0;
        endcase
        r.z = r.o == 0;
        return r;
    endfunction

    task automatic run32(input string nm, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input res_t e);
        int   n;
        logic b0;
        ALUctl = c; A = a; B = b; start = 1;
        @(posedge clock); #1 start = 0;
        b0 = busy;
        n = 1;
        while (!done && n < 200) begin @(posedge clock); #1 n++; end
        chk({nm, " latency"}, 64'(n), 64'(e.lat));
        chk({nm, " busy"}, 64'(b0), 64'(e.lat > 1));
        chk({nm, " out"}, 64'(out), 64'(e.o));
        chk({nm, " out_hi"}, 64'(out_hi), 64'(e.h));
        chk({nm, " Zero"}, 64'(Zero), 64'(e.z));
        chk({nm, " Overflow"}, 64'(Overflow), 64'(e.ov));
        chk({nm, " div_by_zero"}, 64'(div_by_zero), 64'(e.dbz));
        chk({nm, " busy at done"}, 64'(busy), 64'd0);
        @(posedge clock); #1;
        chk({nm, " done pulse"}, 64'(done), 64'd0);
    endtask

    task automatic run8(input string nm, input logic [3:0] c, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eo, input logic [7:0] eh, input logic ez, input int elat);
        int n;
        ctl8 = c; a8 = a; b8 = b; start8 = 1;
        @(posedge clock); #1 start8 = 0;
        n = 1;
        while (!done8 && n < 50) begin @(posedge clock); #1 n++; end
        chk({nm, " latency"}, 64'(n), 64'(elat));
        chk({nm, " out"}, 64'(out8), 64'(eo));
        chk({nm, " out_hi"}, 64'(hi8), 64'(eh));
        chk({nm, " Zero"}, 64'(z8), 64'(ez));
        @(posedge clock); #1;
        chk({nm, " done pulse"}, 64'(done8), 64'd0);
    endtask

    initial begin
        vec_t       tbl[$];
        logic [3:0] codes[10] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd8, 4'd9, 4'd15, 4'd3};
        int         n;
        logic       seen;
        logic [3:0] c;
        logic [31:0] a, b;

        tbl.push_back('{4'd2,  32'd5,        32'd7,        '{32'd12,       32'd0,        0, 0, 0, 1}});
        tbl.push_back('{4'd2,  32'h7FFFFFFF, 32'd1,        '{32'h80000000, 32'd0,        0, 1, 0, 1}});
        tbl.push_back('{4'd6,  32'd3,        32'd3,        '{32'd0,        32'd0,        1, 0, 0, 1}});
        tbl.push_back('{4'd7,  32'hFFFFFFFF, 32'd1,        '{32'd1,        32'd0,        0, 0, 0, 1}});
        tbl.push_back('{4'd7,  32'd1,        32'hFFFFFFFF, '{32'd0,        32'd0,        1, 0, 0, 1}});
        tbl.push_back('{4'd0,  32'hF0F0F0F0, 32'hFF00FF00, '{32'hF000F000, 32'd0,        0, 0, 0, 1}});
        tbl.push_back('{4'd1,  32'hF0F0F0F0, 32'hFF00FF00, '{32'hFFF0FFF0, 32'd0,        0, 0, 0, 1}});
        tbl.push_back('{4'd12, 32'd0,        32'd0,        '{32'hFFFFFFFF, 32'd0,        0, 0, 0, 1}});
        tbl.push_back('{4'd6,  32'h80000000, 32'd1,        '{32'h7FFFFFFF, 32'd0,        0, 1, 0, 1}});
        tbl.push_back('{4'd9,  32'd100,      32'd7,        '{32'd14,       32'd2,        0, 0, 0, 33}});
        tbl.push_back('{4'd9,  32'd9,        32'd0,        '{32'hFFFFFFFF, 32'd9,        0, 0, 1, 1}});
        tbl.push_back('{4'd2,  32'd1,        32'd2,        '{32'd3,        32'd0,        0, 0, 0, 1}});
        tbl.push_back('{4'd8,  32'hFFFFFFFF, 32'hFFFFFFFF, '{32'd1,        32'hFFFFFFFE, 0, 0, 0, 33}});
        tbl.push_back('{4'd15, 32'd5,        32'd6,        '{32'd0,        32'd0,        1, 0, 0, 1}});
        tbl.push_back('{4'd3,  32'd5,        32'd6,        '{32'd0,        32'd0,        1, 0, 0, 1}});
        tbl.push_back('{4'd8,  32'd0,        32'd5,        '{32'd0,        32'd0,        1, 0, 0, 33}});
        tbl.push_back('{4'd9,  32'd5,        32'd10,       '{32'd0,        32'd5,        1, 0, 0, 33}});

        #2;
        chk("reset out", 64'(out), 64'd0);
        chk("reset busy/done", {62'd0, busy, done}, 64'd0);
        repeat (2) @(posedge clock);
        #1 reset = 0;

        foreach (tbl[i]) run32($sformatf("vec%0d", i), tbl[i].c, tbl[i].a, tbl[i].b, tbl[i].e);

        // back-to-back: SLT accepted on the edge where SUB's done shows
        ALUctl = 4'd6; A = 3; B = 3; start = 1;
        @(posedge clock); #1;
        chk("b2b sub done", 64'(done), 64'd1);
        chk("b2b sub out/zero", {31'd0, out, Zero}, {31'd0, 32'd0, 1'b1});
        ALUctl = 4'd7; A = 32'hFFFFFFFF; B = 1;
        @(posedge clock); #1 start = 0;
        chk("b2b slt done", 64'(done), 64'd1);
        chk("b2b slt out", 64'(out), 64'd1);
        @(posedge clock); #1;

        // MULTU with start pulses while busy: ignored, not queued
        ALUctl = 4'd8; A = 32'hFFFFFFFF; B = 2; start = 1;
        @(posedge clock); #1 start = 0;
        n = 1;
        while (!done && n < 200) begin
            start = (n % 5 == 1); ALUctl = 4'd2; A = 1; B = 1;
            @(posedge clock); #1 n++;
        end
        start = 0;
        chk("mul busy latency", 64'(n), 64'd33);
        chk("mul busy out", 64'(out), 64'hFFFFFFFE);
        chk("mul busy out_hi", 64'(out_hi), 64'd1);
        seen = 0;
        repeat (5) begin @(posedge clock); #1 seen |= done; end
        chk("mul no queued op", 64'(seen), 64'd0);

        // async reset in the middle of a MULTU
        ALUctl = 4'd8; A = 5; B = 5; start = 1;
        @(posedge clock); #1 start = 0;
        repeat (9) @(posedge clock);
        #3 reset = 1;
        #1;
        chk("midreset outs", {out, out_hi}, 64'd0);
        chk("midreset flags", {59'd0, Zero, Overflow, div_by_zero, busy, done}, 64'd0);
        @(posedge clock); #1 reset = 0;
        seen = 0;
        repeat (40) begin @(posedge clock); #1 seen |= done; end
        chk("midreset no done", 64'(seen), 64'd0);
        run32("after reset add", 4'd2, 32'd1, 32'd1, '{32'd2, 32'd0, 0, 0, 0, 1});

        run8("w8 multu", 4'd8, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b0, 9);
        run8("w8 undef", 4'd15, 8'h12, 8'h34, 8'h00, 8'h00, 1'b1, 1);
        run8("w8 divu", 4'd9, 8'd200, 8'd9, 8'd22, 8'd2, 1'b0, 9);
        run8("w8 add", 4'd2, 8'd250, 8'd6, 8'd0, 8'd0, 1'b1, 1);

        for (int i = 0; i < 60; i++) begin
            c = codes[$urandom_range(0, 9)];
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 :
                ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            if ($urandom_range(0, 5) == 0) b = a;
            run32($sformatf("rnd%0d c=%0d a=%0h b=%0h", i, c, a, b), c, a, b, model(c, a, b));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
